// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared RV32I fetch constants (NOP encoding, reset PC, word width) and fetch FSM state type
package rv32i_pkg;
   localparam int INST_W = 32;
   localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
   typedef enum logic {RUN, HALT} fetch_state_e;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory read bus; master drives imem_addr, slave returns instruccion combinationally
interface fetch_unit_if #(parameter int IM_AW = 5);
   import rv32i_pkg::*;
   logic [IM_AW-1:0] imem_addr;
   logic [INST_W-1:0] instruccion;
   modport master (output imem_addr, input instruccion);
   modport slave (input imem_addr, output instruccion);
endinterface

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register; ports clk/rst, load/flush controls, inst/pc inputs, valid/inst/pc/pc4 outputs
module if_id_reg
   import rv32i_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              flush,
   input  logic [INST_W-1:0] inst,
   input  logic [31:0]       pc,
   output logic              valid,
   output logic [INST_W-1:0] inst_q,
   output logic [31:0]       pc_q,
   output logic [31:0]       pc4_q
);
   // flush only invalidates and inserts a NOP; pc fields keep their last value
   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= 1'b0;
         inst_q <= NOP_INST;
         pc_q <= '0;
         pc4_q <= '0;
      end else if (flush) begin
         valid <= 1'b0;
         inst_q <= NOP_INST;
      end else if (load) begin
         valid <= 1'b1;
         inst_q <= inst;
         pc_q <= pc;
         pc4_q <= pc + 32'd4;
      end
   end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage; ports clk/rst, stall/redirect/halt_req controls, IM bus (im), IF/ID outputs, pc_q, halted, misalign_err, fetch_count
module fetch_unit
   import rv32i_pkg::*;
#(
   parameter int          IM_AW    = 5,
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              redirect,
   input  logic [31:0]       redirect_target,
   input  logic              halt_req,
   fetch_unit_if.master      im,
   output logic [31:0]       pc_q,
   output logic              if_id_valid,
   output logic [INST_W-1:0] if_id_inst,
   output logic [31:0]       if_id_pc,
   output logic [31:0]       if_id_pc4,
   output logic              halted,
   output logic              misalign_err,
   output logic [31:0]       fetch_count
);
   fetch_state_e state_q, state_d;
   logic [31:0] pc_d, count_d;
   logic load, flush, mis_d;
   assign im.imem_addr = pc_q[IM_AW+1:2];
   assign halted = state_q == HALT;
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         pc_q <= RESET_PC;
         fetch_count <= '0;
         misalign_err <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q <= pc_d;
         fetch_count <= count_d;
         misalign_err <= mis_d;
      end
   end
   // HALT falls through with all defaults: nothing moves until reset
   always_comb begin
      state_d = state_q;
      pc_d = pc_q;
      count_d = fetch_count;
      mis_d = misalign_err;
      load = 1'b0;
      flush = 1'b0;
      if (state_q == RUN) begin
         if (halt_req) begin
            state_d = HALT;
            flush = 1'b1;
         end else if (redirect && redirect_target[1:0] != 2'b00) begin
            state_d = HALT;
            mis_d = 1'b1;
            flush = 1'b1;
         end else if (redirect) begin
            pc_d = redirect_target;
            flush = 1'b1;
         end else if (!stall) begin
            load = 1'b1;
            pc_d = pc_q + 32'd4;
            count_d = &fetch_count ? fetch_count : fetch_count + 32'd1;
         end
      end
   end
   if_id_reg u_if_id (
      .clk(clk),
      .rst(rst),
      .load(load),
      .flush(flush),
      .inst(im.instruccion),
      .pc(pc_q),
      .valid(if_id_valid),
      .inst_q(if_id_inst),
      .pc_q(if_id_pc),
      .pc4_q(if_id_pc4)
   );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed-vector scoreboard bench for fetch_unit
module tb_fetch_unit;
   import rv32i_pkg::*;
   logic clk = 1'b0, rst = 1'b1, stall = 1'b0, redirect = 1'b0, halt_req = 1'b0;
   logic [31:0] redirect_target = '0;
   logic [31:0] pc_q, if_id_inst, if_id_pc, if_id_pc4, fetch_count;
   logic if_id_valid, halted, misalign_err;
   logic [31:0] mem [32];
   logic [168:0] q [$];
   int vectors = 0, miscompares = 0;
   fetch_unit_if #(.IM_AW(5)) im ();
   assign im.instruccion = mem[im.imem_addr];
   fetch_unit #(.IM_AW(5), .RESET_PC(32'h0)) dut (
      .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
      .redirect_target(redirect_target), .halt_req(halt_req), .im(im),
      .pc_q(pc_q), .if_id_valid(if_id_valid), .if_id_inst(if_id_inst),
      .if_id_pc(if_id_pc), .if_id_pc4(if_id_pc4), .halted(halted),
      .misalign_err(misalign_err), .fetch_count(fetch_count)
   );
   always #5 clk = ~clk;
   // expected post-edge state: {pc, addr, valid, inst, ifpc, pc4, count, halted, mis}
   task automatic v(input logic r, st, rd, h, input logic [31:0] tgt,
                    input logic [31:0] epc, input logic ev, input logic [31:0] einst, eifpc, epc4, ecnt,
                    input logic eh, em);
      @(negedge clk);
      rst = r; stall = st; redirect = rd; halt_req = h; redirect_target = tgt;
      q.push_back({epc, epc[6:2], ev, einst, eifpc, epc4, ecnt, eh, em});
   endtask
   always @(posedge clk) begin
      #1;
      if (q.size() > 0) begin
         logic [168:0] exp_v, act_v;
         exp_v = q.pop_front();
         act_v = {pc_q, im.imem_addr, if_id_valid, if_id_inst, if_id_pc, if_id_pc4, fetch_count, halted, misalign_err};
         vectors++;
         if (act_v !== exp_v) begin
            miscompares++;
            $display("FAIL vec%0d {pc,addr,v,inst,ifpc,pc4,cnt,h,m} got %h want %h", vectors, act_v, exp_v);
         end
      end
   end
   initial begin
      for (int i = 0; i < 32; i++) mem[i] = 32'hA0 + i;
      // reset, then four sequential fetches
      v(1,0,0,0,0,       0,0,NOP_INST,0,0,0,0,0);
      v(0,0,0,0,0,       4,1,32'hA0,0,4,1,0,0);
      v(0,0,0,0,0,       8,1,32'hA1,4,8,2,0,0);
      v(0,0,0,0,0,      12,1,32'hA2,8,12,3,0,0);
      v(0,0,0,0,0,      16,1,32'hA3,12,16,4,0,0);
      // stall at pc 8 for three cycles, then release
      v(1,0,0,0,0,       0,0,NOP_INST,0,0,0,0,0);
      v(0,0,0,0,0,       4,1,32'hA0,0,4,1,0,0);
      v(0,0,0,0,0,       8,1,32'hA1,4,8,2,0,0);
      for (int i = 0; i < 3; i++) v(0,1,0,0,0, 8,1,32'hA1,4,8,2,0,0);
      v(0,0,0,0,0,      12,1,32'hA2,8,12,3,0,0);
      // redirect beats stall, then fetch from target
      v(0,1,1,0,32'h40, 32'h40,0,NOP_INST,8,12,3,0,0);
      v(0,0,0,0,0,      32'h44,1,32'hB0,32'h40,32'h44,4,0,0);
      // misaligned redirect halts; HALT absorbs everything until reset
      v(0,0,1,0,32'h42, 32'h44,0,NOP_INST,32'h40,32'h44,4,1,1);
      v(0,0,1,0,32'h80, 32'h44,0,NOP_INST,32'h40,32'h44,4,1,1);
      v(0,0,0,0,0,      32'h44,0,NOP_INST,32'h40,32'h44,4,1,1);
      v(0,0,0,1,0,      32'h44,0,NOP_INST,32'h40,32'h44,4,1,1);
      v(1,0,0,0,0,       0,0,NOP_INST,0,0,0,0,0);
      // 32 fetches wrap the IM address back to 0
      for (int k = 1; k <= 32; k++) v(0,0,0,0,0, 4*k,1,32'hA0+k-1,4*(k-1),4*k,k,0,0);
      // PC wraps modulo 2^32
      v(0,0,1,0,32'hFFFF_FFFC, 32'hFFFF_FFFC,0,NOP_INST,32'h7C,32'h80,32,0,0);
      v(0,0,0,0,0,      0,1,32'hBF,32'hFFFF_FFFC,0,33,0,0);
      // halt_req outranks redirect; no misalign flag
      v(0,0,1,1,32'h40, 0,0,NOP_INST,32'hFFFF_FFFC,0,33,1,0);
      v(0,0,0,0,0,      0,0,NOP_INST,32'hFFFF_FFFC,0,33,1,0);
      // reset with a redirect pending discards it
      v(1,0,1,0,32'h40, 0,0,NOP_INST,0,0,0,0,0);
      v(0,0,0,0,0,       4,1,32'hA0,0,4,1,0,0);
      for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
      if (q.size() > 0) begin
         miscompares++;
         $display("FAIL drain: %0d vectors still pending, want 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage; sits directly upstream of the memory block's instruction memory (IM).
- Holds the program counter and drives the IM word address. It captures the returned instruction, together with its PC and PC+4, into an IF/ID pipeline register for decode.
- Handles stall, branch/jump redirect, halt request and misaligned-target detection.
- IM read is combinational: the address is presented and `instruccion` is valid in the same cycle.

Parameters:
- IM_AW, 5, IM word-address width; `imem_addr` = `pc_q[IM_AW+1:2]`.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- stall  in  1  hazard stall from decode; hold PC and IF/ID.
- redirect  in  1  taken branch/jump (PCSrc).
- redirect_target  in  32  byte address of the redirect target.
- halt_req  in  1  ecall/ebreak seen in decode; stop fetching.
- instruccion  in  32  instruction word from IM.
- imem_addr  out  IM_AW  IM word address, combinational from `pc_q`.
- pc_q  out  32  current fetch PC (byte address).
- if_id_valid  out  1  IF/ID holds a real instruction.
- if_id_inst  out  32  latched instruction (NOP when invalid).
- if_id_pc  out  32  PC of the latched instruction.
- if_id_pc4  out  32  `if_id_pc` + 4.
- halted  out  1  FSM is in HALT.
- misalign_err  out  1  sticky: redirect target not word-aligned.
- fetch_count  out  32  count of instructions loaded into IF/ID; saturating.

Behaviour:
- Reset (`rst`=1 at posedge), all outputs:
  - `pc_q`=RESET_PC, state=RUN
  - `if_id_valid`=0, `if_id_inst`=NOP (32'h0000_0013), `if_id_pc`=0, `if_id_pc4`=0
  - `halted`=0, `misalign_err`=0, `fetch_count`=0
  - Reset mid-operation discards everything, including a pending redirect.
- FSM states: RUN, HALT.
- RUN, evaluated each posedge in strict priority order:
  1. `halt_req`=1 -> HALT. `pc_q` held. IF/ID flushed (valid=0, inst=NOP).
  2. `redirect`=1 with `redirect_target[1:0]`≠0 -> HALT. `misalign_err`<=1, `pc_q` held, IF/ID flushed.
  3. `redirect`=1, aligned -> `pc_q`<=`redirect_target`. IF/ID flushed. Count unchanged. Redirect overrides `stall` in the same cycle.
  4. `stall`=1 -> `pc_q`, IF/ID and count all hold.
  5. Otherwise:
     - IF/ID <= {valid=1, inst=`instruccion`, pc=`pc_q`, pc4=`pc_q`+4}.
     - `pc_q`<=`pc_q`+4.
     - `fetch_count`<=`fetch_count`+1, saturating at 32'hFFFF_FFFF.
- HALT: absorbing until `rst`.
  - `pc_q` frozen; `if_id_valid`=0; all other inputs ignored.
  - `halted`=1 (registered, first asserted the cycle after entry).
- Latency: an instruction at PC P appears in IF/ID one cycle after `pc_q`=P (unstalled). The first valid IF/ID entry appears on the 1st posedge after `rst` deasserts.
- Width/wrap:
  - PC arithmetic is 32-bit modulo 2^32; 32'hFFFF_FFFC + 4 = 0.
  - `imem_addr` truncates, so a PC beyond IM depth wraps in IM without error.
  - `pc_q[1:0]` is always 0 (reset and redirects are aligned; misaligned targets halt).
- Outputs are registered except `imem_addr`.

Decomposition:
- Shared package `rv32i_pkg`:
  - NOP_INST = 32'h0000_0013
  - default RESET_PC
  - fetch FSM state enum {RUN, HALT}
  - INST_W = 32
- Sub-module `if_id_reg`: IF/ID register with load/hold/flush controls and the valid bit. The `fetch_unit` top keeps the PC, FSM and counter.

Test Plan:
- Reset release, no stall, IM holds 0xA0..0xA3 at words 0..3 -> after 4 posedges `if_id_pc`=12, `if_id_inst`=0xA3, `pc_q`=16, `fetch_count`=4, `imem_addr`=4.
- `stall`=1 for 3 cycles at `pc_q`=8 -> `pc_q`, IF/ID and count unchanged for 3 cycles; release -> `if_id_pc`=8 next cycle.
- `redirect`=1, target=0x40, same cycle as `stall`=1 -> next cycle `pc_q`=0x40, `if_id_valid`=0, `if_id_inst`=0x13; following cycle `if_id_pc`=0x40, `if_id_pc4`=0x44.
- `redirect`=1, target=0x42 -> `misalign_err`=1, `halted`=1, `pc_q` unchanged; further redirects and non-stalled cycles leave `pc_q` and count fixed; `rst` clears all flags.
- PC wrap: after 32 sequential fetches, `imem_addr` returns to 0, `pc_q`=0x80, count=32; separately force `pc_q` to 0xFFFF_FFFC via redirect -> next `pc_q`=0.
- `halt_req` and `redirect` asserted together -> HALT; `pc_q` not updated to the target; `misalign_err` stays 0.
